// File: rtl/count_run_pkg.sv
// count_run_pkg: shared types and constants for the
// counting-run controller and its gate timer.
package count_run_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    LATCH = 3'd3,
    DONE  = 3'd4
  } run_state_t;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;
  localparam int CH_DEFAULT_NCH = 32;

endpackage

// File: rtl/count_run_ctrl_gate_timer.sv
// run_gate_timer: latched gate length plus saturating
// count of cycles the gate has been open.
//  clk, reset   : clock, sync active-high reset
//  load         : capture gate_len (run accepted)
//  gate_len     : run length, 0 = unlimited
//  clr          : zero the cycle counter
//  inc          : count one open-gate cycle
//  run_cycles   : open-gate cycles so far
//  expire       : current cycle is the last of the run
module run_gate_timer
  import count_run_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] gate_len,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] run_cycles,
  output logic        expire
);

  logic [31:0] gate_q, gate_d;
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    gate_d = gate_q;
    cyc_d  = cyc_q;
    if (load) gate_d = gate_len;
    if (clr) begin
      cyc_d = '0;
    end else if (inc && cyc_q != CNT_MAX) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gate_q <= '0;
      cyc_q  <= '0;
    end else begin
      gate_q <= gate_d;
      cyc_q  <= cyc_d;
    end
  end

  // Fires in the Nth open cycle, so the gate is open exactly N cycles.
  // At saturation cyc_q+1 wraps to 0, which never matches a nonzero gate.
  assign expire     = (gate_q != '0) && (cyc_q + 32'd1 == gate_q);
  assign run_cycles = cyc_q;

endmodule

// File: rtl/count_run_ctrl.sv
// count_run_ctrl: sequences one counting run (clear, gate, close)
// and snapshots all channels into a CPU-readable shadow bank.
//  clk, reset          : clock, sync active-high reset
//  cmd_start/cmd_abort : 1-cycle command pulses
//  gate_len            : run length in cycles, 0 = unlimited
//  stop_step           : level; rising edge ends the run
//  ch_count            : live counters, ch i at [i*CW +: CW]
//  cnt_clr/cnt_en      : counter clear pulse / count gate
//  rd_sel/rd_data      : registered shadow readout
//  run_cycles          : open-gate cycles of last run
//  busy/done/aborted   : run status
module count_run_ctrl
  import count_run_pkg::*;
#(
  parameter int NCH  = CH_DEFAULT_NCH,
  parameter int CW   = 32,
  parameter int SELW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic              cmd_abort,
  input  logic [31:0]       gate_len,
  input  logic              stop_step,
  input  logic [NCH*CW-1:0] ch_count,
  output logic              cnt_clr,
  output logic              cnt_en,
  input  logic [SELW-1:0]   rd_sel,
  output logic [CW-1:0]     rd_data,
  output logic [31:0]       run_cycles,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  run_state_t state_q, state_d;
  logic       stop_prev_q, stop_prev_d;
  logic       done_q, done_d;
  logic       aborted_q, aborted_d;
  logic [CW-1:0] shadow_q [NCH];
  logic [CW-1:0] shadow_d [NCH];
  logic [CW-1:0] rd_data_q, rd_data_d;

  logic start_ok;
  logic stop_rise;
  logic expire;

  // Abort beats a simultaneous start only from IDLE.
  assign start_ok = cmd_start &&
    ((state_q == IDLE && !cmd_abort) || state_q == DONE);

  assign stop_rise = stop_step && !stop_prev_q;

  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    aborted_d   = aborted_q;
    shadow_d    = shadow_q;
    // Sampled every cycle, including CLEAR, so a level already
    // high when the run starts is not mistaken for an edge.
    stop_prev_d = stop_step;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d   = CLEAR;
          done_d    = 1'b0;
          aborted_d = 1'b0;
        end
      end
      CLEAR: state_d = RUN;
      RUN: begin
        if (cmd_abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (stop_rise || expire) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        state_d = DONE;
        done_d  = 1'b1;
        for (int i = 0; i < NCH; i++) begin
          shadow_d[i] = ch_count[i*CW +: CW];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // During LATCH read the incoming value so rd_data changes only
  // at the snapshot edge and stays stable in DONE.
  always_comb begin
    rd_data_d = '0;
    if (32'(rd_sel) < NCH) begin
      if (state_q == LATCH) begin
        rd_data_d = ch_count[32'(rd_sel)*CW +: CW];
      end else begin
        rd_data_d = shadow_q[rd_sel];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      stop_prev_q <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      rd_data_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      stop_prev_q <= stop_prev_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      rd_data_q   <= rd_data_d;
      shadow_q    <= shadow_d;
    end
  end

  run_gate_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (start_ok),
    .gate_len   (gate_len),
    .clr        (state_q == CLEAR),
    .inc        (state_q == RUN),
    .run_cycles (run_cycles),
    .expire     (expire)
  );

  assign cnt_clr = (state_q == CLEAR);
  assign cnt_en  = (state_q == RUN);
  assign busy    = (state_q == CLEAR) || (state_q == RUN) ||
                   (state_q == LATCH);
  assign done    = done_q;
  assign aborted = aborted_q;
  assign rd_data = rd_data_q;

endmodule
